// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared types and defaults for the seq_match_ctrl slice.
//   state_e       - frame controller state encoding
//   DEF_IDLE_BYTE - default filler byte driven on bubbles and drain
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam logic [7:0] DEF_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/seq_tag_pipe.sv
// seq_tag_pipe: DEPTH-deep shift register of {valid, pos} tags that tracks
// bytes through the detector latency. Resets to all-invalid.
//   clk, rst            - clock, async active-high reset
//   in_valid, in_pos    - tag entering the pipe
//   out_valid, out_pos  - tag leaving the pipe, aligned with the detector match
module seq_tag_pipe #(
  parameter int unsigned POS_W = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [POS_W-1:0] in_pos,
  output logic             out_valid,
  output logic [POS_W-1:0] out_pos
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][POS_W-1:0] pos_q;

  // Plain shift: stage 0 takes the new tag, every other stage takes its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      pos_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      pos_q[0] <= in_pos;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        pos_q[i] <= pos_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_pos   = pos_q[DEPTH-1];

endmodule

// File: rtl/seq_match_ctrl.sv
// seq_match_ctrl: frame-level sequencer for the shared byte sequence detector.
// Resets the detector before each frame, streams one byte per clock (filler on
// bubbles), counts detector matches and reports a per-frame result.
//   CLK, RST                  - clock, async active-high reset
//   S_VALID/S_READY/S_DATA/S_LAST - input byte stream
//   DET_RST, DET_D_IN, DET_MATCH  - detector control, byte and match flag
//   R_VALID/R_READY, R_COUNT, R_HIT, R_FIRST_POS, R_ABORT - frame report
// Build option: SEQ_CTRL_TIMEOUT_EN adds the consecutive-bubble abort.
module seq_match_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned POS_W      = 16,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned MATCH_LAT  = 1,
  parameter logic [7:0]  IDLE_BYTE  = DEF_IDLE_BYTE,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [7:0]       S_DATA,
  input  logic             S_LAST,
  output logic             DET_RST,
  output logic [7:0]       DET_D_IN,
  input  logic             DET_MATCH,
  output logic             R_VALID,
  input  logic             R_READY,
  output logic [CNT_W-1:0] R_COUNT,
  output logic             R_HIT,
  output logic [POS_W-1:0] R_FIRST_POS,
  output logic             R_ABORT
);

  localparam int unsigned PH_MAX = (CLR_CYCLES > MATCH_LAT + 1) ? CLR_CYCLES : MATCH_LAT + 1;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  state_e           state;
  logic [PH_W-1:0]  ph_q;       // cycle counter for CLEAR and DRAIN
  logic [POS_W-1:0] pos_q;      // index of the next accepted byte
  logic             tag_vld_q;  // tag travelling alongside DET_D_IN
  logic [POS_W-1:0] tag_pos_q;
  logic             pipe_vld;
  logic [POS_W-1:0] pipe_pos;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] bub_q;
  logic            abort_q;
  assign R_ABORT = abort_q;
`else
  assign R_ABORT = 1'b0;
`endif

  // Tags line up with DET_MATCH: one register here plus MATCH_LAT in the pipe.
  seq_tag_pipe #(
    .POS_W (POS_W),
    .DEPTH (MATCH_LAT)
  ) u_tag_pipe (
    .clk       (CLK),
    .rst       (RST),
    .in_valid  (tag_vld_q),
    .in_pos    (tag_pos_q),
    .out_valid (pipe_vld),
    .out_pos   (pipe_pos)
  );

  // Frame FSM with registered outputs and match accounting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      ph_q        <= '0;
      pos_q       <= '0;
      tag_vld_q   <= 1'b0;
      tag_pos_q   <= '0;
      S_READY     <= 1'b0;
      DET_RST     <= 1'b1;
      DET_D_IN    <= IDLE_BYTE;
      R_VALID     <= 1'b0;
      R_COUNT     <= '0;
      R_HIT       <= 1'b0;
      R_FIRST_POS <= '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      bub_q       <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      // Filler and an invalid tag unless a byte is accepted below.
      DET_D_IN  <= IDLE_BYTE;
      tag_vld_q <= 1'b0;
      tag_pos_q <= '0;

      // Only matches tied to a real byte of this frame count.
      if ((state == ST_STREAM || state == ST_DRAIN) && DET_MATCH && pipe_vld) begin
        if (R_COUNT != '1) R_COUNT <= R_COUNT + CNT_W'(1);
        if (!R_HIT) begin
          R_HIT       <= 1'b1;
          R_FIRST_POS <= pipe_pos;
        end
      end

      case (state)
        ST_IDLE: begin
          if (S_VALID) begin
            state       <= ST_CLEAR;
            ph_q        <= '0;
            pos_q       <= '0;
            R_COUNT     <= '0;
            R_HIT       <= 1'b0;
            R_FIRST_POS <= '0;
`ifdef SEQ_CTRL_TIMEOUT_EN
            bub_q       <= '0;
            abort_q     <= 1'b0;
`endif
          end
        end

        ST_CLEAR: begin
          if (ph_q == PH_W'(CLR_CYCLES - 1)) begin
            state   <= ST_STREAM;
            S_READY <= 1'b1;
            DET_RST <= 1'b0;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end

        ST_STREAM: begin
          if (S_VALID) begin
            DET_D_IN  <= S_DATA;
            tag_vld_q <= 1'b1;
            tag_pos_q <= pos_q;
            if (pos_q != '1) pos_q <= pos_q + POS_W'(1);
`ifdef SEQ_CTRL_TIMEOUT_EN
            bub_q <= '0;
`endif
            if (S_LAST) begin
              state   <= ST_DRAIN;
              S_READY <= 1'b0;
              ph_q    <= '0;
            end
          end
`ifdef SEQ_CTRL_TIMEOUT_EN
          else if (bub_q == TO_W'(TIMEOUT - 1)) begin
            state   <= ST_DRAIN;
            S_READY <= 1'b0;
            ph_q    <= '0;
            abort_q <= 1'b1;
          end else begin
            bub_q <= bub_q + TO_W'(1);
          end
`endif
        end

        // MATCH_LAT+1 filler cycles let the last byte's match come back.
        ST_DRAIN: begin
          if (ph_q == PH_W'(MATCH_LAT)) begin
            state   <= ST_REPORT;
            R_VALID <= 1'b1;
            DET_RST <= 1'b1;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end

        ST_REPORT: begin
          if (R_READY) begin
            state   <= ST_IDLE;
            R_VALID <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb_seq_match_ctrl: directed plus randomized frames against a frame-level
// reference model; a second instance with CNT_W=2 checks count saturation.
module tb_seq_match_ctrl;

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif
  localparam int unsigned CLR = 2;
  localparam int unsigned ML  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_last, r_ready;
  logic [7:0]  s_data;
  logic        s_ready, det_rst, det_match, r_valid, r_hit, r_abort;
  logic [7:0]  det_d;
  logic [7:0]  r_count;
  logic [15:0] r_pos;
  logic        s_ready2, det_rst2, det_match2, r_valid2, r_hit2, r_abort2;
  logic [7:0]  det_d2;
  logic [1:0]  r_count2;
  logic [15:0] r_pos2;

  always #5 clk = ~clk;

  seq_match_ctrl #(.CNT_W(8), .POS_W(16), .CLR_CYCLES(CLR), .MATCH_LAT(ML),
                   .IDLE_BYTE(8'h00), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .S_LAST(s_last), .DET_RST(det_rst), .DET_D_IN(det_d), .DET_MATCH(det_match),
    .R_VALID(r_valid), .R_READY(r_ready), .R_COUNT(r_count), .R_HIT(r_hit),
    .R_FIRST_POS(r_pos), .R_ABORT(r_abort));

  seq_match_ctrl #(.CNT_W(2), .POS_W(16), .CLR_CYCLES(CLR), .MATCH_LAT(ML),
                   .IDLE_BYTE(8'h00), .TIMEOUT(TO)) dut2 (
    .CLK(clk), .RST(rst), .S_VALID(s_valid), .S_READY(s_ready2), .S_DATA(s_data),
    .S_LAST(s_last), .DET_RST(det_rst2), .DET_D_IN(det_d2), .DET_MATCH(det_match2),
    .R_VALID(r_valid2), .R_READY(r_ready), .R_COUNT(r_count2), .R_HIT(r_hit2),
    .R_FIRST_POS(r_pos2), .R_ABORT(r_abort2));

  // Detector stand-ins: pattern A5,3C, match one cycle after the byte.
  logic [7:0] prev1, prev2;
  always @(posedge clk) begin
    if (det_rst) begin prev1 <= 8'h00; det_match <= 1'b0; end
    else begin det_match <= (prev1 == 8'hA5) && (det_d == 8'h3C); prev1 <= det_d; end
  end
  always @(posedge clk) begin
    if (det_rst2) begin prev2 <= 8'h00; det_match2 <= 1'b0; end
    else begin det_match2 <= (prev2 == 8'hA5) && (det_d2 == 8'h3C); prev2 <= det_d2; end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Current frame: bytes and the number of bubbles inserted before each.
  logic [7:0] fr_b[$];
  int         fr_bub[$];
  // What the detector sees during STREAM, one entry per cycle.
  logic [7:0] m_byte[$];
  bit         m_real[$];
  int         m_pos[$];
  logic [7:0] pool [6] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h11, 8'h00};

  task automatic wait_ready(output int w);
    w = 0;
    do begin @(posedge clk); w++; @(negedge clk); end while (!s_ready && w < 20);
  endtask

  task automatic run_frame(input int hold, input bit poke);
    int n, i, w, exp_cnt, exp_first;
    bit exp_hit;
    logic [7:0] pb;
    n = fr_b.size();
    i = 0;
    m_byte.delete(); m_real.delete(); m_pos.delete();
    s_valid = 1'b1; s_data = fr_b[0]; s_last = (n == 1);
    wait_ready(w);
    check("ready_latency", w, CLR + 1);
    while (i < n) begin
      for (int b = 0; b < fr_bub[i]; b++) begin
        check("stream_ready", s_ready, 1'b1);
        s_valid = 1'b0;
        m_byte.push_back(8'h00); m_real.push_back(1'b0); m_pos.push_back(0);
        @(posedge clk); @(negedge clk);
      end
      check("stream_ready", s_ready, 1'b1);
      s_valid = 1'b1; s_data = fr_b[i]; s_last = (i == n - 1);
      m_byte.push_back(fr_b[i]); m_real.push_back(1'b1); m_pos.push_back(i);
      @(posedge clk); @(negedge clk);
      i++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    w = 0;
    while (!r_valid && w < 20) begin @(posedge clk); w++; @(negedge clk); end
    check("report_latency", w, ML + 1);
    // Reference: a real 3C directly preceded (in detector view) by A5 is a match.
    exp_cnt = 0; exp_hit = 1'b0; exp_first = 0;
    for (int j = 0; j < m_byte.size(); j++) begin
      pb = (j == 0) ? 8'h00 : m_byte[j-1];
      if (m_real[j] && pb == 8'hA5 && m_byte[j] == 8'h3C) begin
        if (!exp_hit) exp_first = m_pos[j];
        exp_hit = 1'b1;
        exp_cnt++;
      end
    end
    check("r_count", r_count, (exp_cnt > 255) ? 255 : exp_cnt);
    check("r_hit", r_hit, exp_hit);
    check("r_first_pos", r_pos, exp_first);
    check("r_abort", r_abort, 1'b0);
    check("sat_valid", r_valid2, 1'b1);
    check("sat_count", r_count2, (exp_cnt > 3) ? 3 : exp_cnt);
    check("sat_hit", r_hit2, exp_hit);
    check("sat_first_pos", r_pos2, exp_first);
    for (int h = 0; h < hold; h++) begin
      r_ready = 1'b0;
      s_valid = poke;
      @(posedge clk); @(negedge clk);
      check("hold_valid", r_valid, 1'b1);
      check("hold_count", r_count, (exp_cnt > 255) ? 255 : exp_cnt);
      check("hold_first_pos", r_pos, exp_first);
      check("report_not_ready", s_ready, 1'b0);
    end
    s_valid = 1'b0; r_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    r_ready = 1'b0;
    check("ack_valid_low", r_valid, 1'b0);
    check("idle_det_rst", det_rst, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, n, seen;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; r_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_det_rst", det_rst, 1'b1);
    check("rst_det_d", det_d, 8'h00);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_count", r_count, 8'h00);
    check("rst_r_hit", r_hit, 1'b0);
    check("rst_r_pos", r_pos, 16'h0);
    check("rst_r_abort", r_abort, 1'b0);
    check("rst_abort2", r_abort2, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", s_ready, 1'b0);
    check("idle_s_ready2", s_ready2, 1'b0);

    // Single match in a bubble-free frame.
    fr_b = '{8'h11, 8'hA5, 8'h3C, 8'h22}; fr_bub = '{0, 0, 0, 0};
    run_frame(0, 1'b0);
    // Bubble between two pairs must not advance position.
    fr_b = '{8'hA5, 8'h3C, 8'hA5, 8'h3C}; fr_bub = '{0, 0, 1, 0};
    run_frame(1, 1'b0);
    // Report held with R_READY low, then a frame that only matches across frames.
    fr_b = '{8'hA5, 8'h3C}; fr_bub = '{0, 0};
    run_frame(10, 1'b1);
    fr_b = '{8'h3C, 8'hA5}; fr_bub = '{0, 0};
    run_frame(0, 1'b0);
    // Five pairs saturate the 2-bit counter.
    fr_b = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    fr_bub = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(2, 1'b0);

    // Reset in the middle of a frame discards it.
    s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
    wait_ready(w);
    check("mid_ready_latency", w, CLR + 1);
    @(posedge clk); @(negedge clk);
    s_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    #1;
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_det_rst", det_rst, 1'b1);
    check("midrst_det_d", det_d, 8'h00);
    check("midrst_r_valid", r_valid, 1'b0);
    check("midrst_r_count", r_count, 8'h00);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (r_valid) seen = 1; end
    check("midrst_no_report", seen, 0);
    fr_b = '{8'h00, 8'hA5, 8'h3C}; fr_bub = '{0, 0, 0};
    run_frame(0, 1'b0);

    // Randomized frames; bubble runs stay below any timeout.
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 10);
      fr_b.delete(); fr_bub.delete();
      for (int k = 0; k < n; k++) begin
        fr_b.push_back(pool[$urandom_range(0, 5)]);
        fr_bub.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
      run_frame($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

`ifdef SEQ_CTRL_TIMEOUT_EN
    // Stall after A5,3C: the frame must abort and still report its match.
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    wait_ready(w);
    @(posedge clk); @(negedge clk);
    s_data = 8'h3C;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    w = 0;
    while (!r_valid && w < 40) begin @(posedge clk); w++; @(negedge clk); end
    check("to_latency", w, TO + ML + 1);
    check("to_abort", r_abort, 1'b1);
    check("to_count", r_count, 8'd1);
    check("to_first_pos", r_pos, 16'd1);
    r_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    r_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Frame-level controller that sequences the shared byte-wide sequence detector (`sequence_det`). It accepts byte frames on a valid/ready stream and resets the detector before each frame. It feeds one byte per clock, inserting a filler byte on source bubbles, and counts detector matches while tracking the position of the first one. It returns a per-frame result on a valid/ready report port. It sits between the byte source and the detector, so the detector never sees bytes from two frames without an intervening reset.

## Interface
- `CNT_W`, 8 — width of the match counter.
- `POS_W`, 16 — width of the byte-position counter.
- `CLR_CYCLES`, 2 — cycles `DET_RST` is held high at frame start; must be ≥1.
- `MATCH_LAT`, 1 — cycles from a byte being presented on `DET_D_IN` to its `DET_MATCH`; must be ≥1.
- `IDLE_BYTE`, 8'h00 — filler byte driven on bubbles and drain; must not occur in the detector pattern.
- `TIMEOUT`, 255 — consecutive bubble cycles before a frame is aborted (only used with `SEQ_CTRL_TIMEOUT_EN`).

Ports:
- `CLK` in 1 — the single clock, rising edge.
- `RST` in 1 — asynchronous, active-high reset.
- `S_VALID` in 1 / `S_READY` out 1 — input byte handshake.
- `S_DATA` in 8 — input byte.
- `S_LAST` in 1 — marks the last byte of the frame.
- `DET_RST` out 1 — detector reset.
- `DET_D_IN` out 8 — detector byte input, registered.
- `DET_MATCH` in 1 — detector match flag.
- `R_VALID` out 1 / `R_READY` in 1 — report handshake.
- `R_COUNT` out CNT_W — number of matches in the frame.
- `R_HIT` out 1 — at least one match occurred.
- `R_FIRST_POS` out POS_W — 0-based index of the byte that completed the first match.
- `R_ABORT` out 1 — frame ended by timeout.

## Operation
- States and the signals driven in each:
  - IDLE: `DET_RST`=1, `S_READY`=0.
  - CLEAR: `DET_RST`=1, `S_READY`=0.
  - STREAM: `DET_RST`=0, `S_READY`=1.
  - DRAIN: `DET_RST`=0, `S_READY`=0.
  - REPORT: `DET_RST`=1, `S_READY`=0, `R_VALID`=1.
- IDLE→CLEAR on `S_VALID`=1. Accumulators are zeroed on this transition.
- CLEAR lasts exactly CLR_CYCLES cycles, then the block moves to STREAM.
- STREAM, byte accepted (`S_VALID`&`S_READY`):
  - `DET_D_IN`<=`S_DATA`.
  - Push tag {valid=1, pos} into the tag pipeline, then increment pos.
- STREAM, no byte accepted (bubble): `DET_D_IN`<=IDLE_BYTE and push an invalid tag. Position does not advance.
- STREAM→DRAIN on an accepted byte with `S_LAST`=1.
- DRAIN drives IDLE_BYTE for MATCH_LAT+1 cycles, then moves to REPORT.
- Match accounting, evaluated every cycle in STREAM and DRAIN:
  - If `DET_MATCH`=1 and the pipeline output tag is valid, increment the count. The count saturates at 2^CNT_W−1.
  - On the first such match, latch the tag's pos into the first-position field and set hit.
  - A match aligned with an invalid tag is ignored.
- The position counter saturates at 2^POS_W−1.
- REPORT holds all `R_*` outputs stable until `R_READY`=1, then moves to IDLE. `S_VALID` during REPORT is not accepted.

## Timing
- Reset values: state IDLE, `S_READY`=0, `DET_RST`=1, `DET_D_IN`=IDLE_BYTE, `R_VALID`=0, `R_COUNT`=0, `R_HIT`=0, `R_FIRST_POS`=0, `R_ABORT`=0.
- `S_VALID` first high in IDLE at cycle 0 → `S_READY` first high at cycle CLR_CYCLES+1.
- A byte accepted at edge t appears on `DET_D_IN` during cycle t+1. Its `DET_MATCH` is sampled in cycle t+1+MATCH_LAT.
- Last byte accepted at edge t → `R_VALID` rises in cycle t+MATCH_LAT+2.
- REPORT with `R_READY`=1 at edge t → IDLE in cycle t+1. The earliest next frame enters CLEAR in cycle t+2.
- `RST` asserted mid-frame: all state and outputs return to reset values immediately. The partial frame is discarded and no report is generated.

## Configuration
- `SEQ_CTRL_TIMEOUT_EN` defined:
  - In STREAM, a consecutive-bubble counter reaches TIMEOUT → go to DRAIN with the abort flag set.
  - The report carries `R_ABORT`=1 with the accumulated count and position.
  - The bubble counter clears on every accepted byte.
- `SEQ_CTRL_TIMEOUT_EN` undefined: no bubble counter is built, `R_ABORT` is tied to 0, and STREAM waits indefinitely.

## Structure
- Package `seq_ctrl_pkg`: state encoding constants (IDLE, CLEAR, STREAM, DRAIN, REPORT) and the default IDLE_BYTE.
- Sub-module `seq_tag_pipe`: a MATCH_LAT-deep shift register of {valid, pos[POS_W-1:0]}, reset to all-invalid.

## Test plan
All scenarios use a detector model matching the pattern A5,3C with MATCH_LAT=1.
- Frame 11,A5,3C,22 (last on 22), no bubbles → `R_COUNT`=1, `R_HIT`=1, `R_FIRST_POS`=2, `R_ABORT`=0.
- Frame A5,3C,A5,3C with a bubble between the two pairs → `R_COUNT`=2, `R_FIRST_POS`=1. The bubble must not advance position.
- Frame A5,3C held with `R_READY`=0 for 10 cycles, then a second frame 3C,A5 → first report holds stable with count 1. The second frame reports `R_COUNT`=0, `R_HIT`=0, proving the detector was reset between frames.
- `RST` pulsed after the 2nd byte of a 4-byte frame → outputs at reset values the same cycle and no `R_VALID`. The next frame 00,A5,3C reports `R_FIRST_POS`=2.
- CNT_W=2, frame of 5 A5,3C pairs → `R_COUNT`=3 (saturated), `R_FIRST_POS`=1.
- With `SEQ_CTRL_TIMEOUT_EN`, TIMEOUT=4: send A5,3C then stall `S_VALID`=0 → report after the timeout plus drain with `R_ABORT`=1, `R_COUNT`=1.
